// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-requester sync_ram controller.
// Requester IDs double as round-robin history and read-return owner tags.
package ram_ctrl_pkg;

    typedef enum logic {
        CLR,
        RUN
    } state_e;

    localparam int unsigned DEF_AW = 4;
    localparam int unsigned DEF_DW = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. gnt is combinational from req; rr_last records
// the most recent winner and only moves on a cycle that actually grants.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_last == REQ_A) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to B so that A wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= REQ_B;
        end else if (|gnt) begin
            rr_last <= gnt[1] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Controller for a single-port sync RAM: optional post-reset clear sweep, then
// round-robin sharing between requesters A and B with tagged read return.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned   AW      = DEF_AW,
    parameter int unsigned   DW      = DEF_DW,
    parameter int unsigned   RD_LAT  = 1,
    parameter bit            CLR_EN  = 1'b1,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,

    output logic          init_done
);

    state_e        state;
    logic [AW-1:0] clr_cnt;
    logic          init_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLR_EN ? CLR : RUN;
            clr_cnt     <= '0;
            init_done_q <= !CLR_EN;
        end else begin
            unique case (state)
                CLR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == {AW{1'b1}}) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign init_done = init_done_q;

    // Gating on rst_n keeps grants low during reset even when the sweep is skipped.
    logic       arb_en;
    logic [1:0] gnt;

    assign arb_en = (state == RUN) && rst_n;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({b_req, a_req}),
        .gnt   (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (state == CLR) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
            ram_din  = CLR_VAL;
        end else if (gnt[0]) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (gnt[1]) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    // Read return: one {valid, owner} slot per cycle of RAM latency.
    logic              rd_push;
    logic              rd_owner;
    logic [RD_LAT-1:0] rv_q;
    logic [RD_LAT-1:0] own_q;

    assign rd_push  = (gnt[0] && !a_we) || (gnt[1] && !b_we);
    assign rd_owner = gnt[1] ? REQ_B : REQ_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q  <= '0;
            own_q <= '0;
        end else begin
            rv_q[0]  <= rd_push;
            own_q[0] <= rd_owner;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rv_q[i]  <= rv_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign a_rvalid = rv_q[RD_LAT-1] && (own_q[RD_LAT-1] == REQ_A);
    assign b_rvalid = rv_q[RD_LAT-1] && (own_q[RD_LAT-1] == REQ_B);
    assign a_rdata  = a_rvalid ? ram_dout : '0;
    assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with behavioural 16x8 sync RAMs; a second
// instance sweeps with 8'hFF to check the clear value reaches memory.
module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;

    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       init_done;

    logic       a2_req;
    logic [3:0] a2_addr;
    logic       a2_gnt, a2_rvalid, b2_gnt, b2_rvalid;
    logic [7:0] a2_rdata, b2_rdata;
    logic       ram2_we;
    logic [3:0] ram2_addr;
    logic [7:0] ram2_din, ram2_dout;
    logic       init2_done;

    int n_checks = 0;
    int n_fails  = 0;

    ram_arbiter #(.AW(4), .DW(8), .RD_LAT(1), .CLR_EN(1'b1), .CLR_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .init_done(init_done)
    );

    ram_arbiter #(.AW(4), .DW(8), .RD_LAT(1), .CLR_EN(1'b1), .CLR_VAL(8'hFF)) dut_ff (
        .clk(clk), .rst_n(rst_n),
        .a_req(a2_req), .a_we(1'b0), .a_addr(a2_addr), .a_wdata(8'h00),
        .a_gnt(a2_gnt), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(4'h0), .b_wdata(8'h00),
        .b_gnt(b2_gnt), .b_rvalid(b2_rvalid), .b_rdata(b2_rdata),
        .ram_we(ram2_we), .ram_addr(ram2_addr), .ram_din(ram2_din), .ram_dout(ram2_dout),
        .init_done(init2_done)
    );

    // Sync RAM models: read latency 1, write commits at the edge.
    logic [7:0] mem  [16];
    logic [7:0] mem2 [16];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (ram2_we) mem2[ram2_addr] <= ram2_din;
        ram2_dout <= mem2[ram2_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        // Both requesters write from the start; they must wait out the sweep.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h0; a_wdata = 8'hA5;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h1; b_wdata = 8'h3C;
        a2_req = 1'b1; a2_addr = 4'h9;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 16'(init_done), 16'h0);
        chk("rst_a_gnt", 16'(a_gnt), 16'h0);
        chk("rst_b_gnt", 16'(b_gnt), 16'h0);
        chk("rst_a_rvalid", 16'(a_rvalid), 16'h0);
        chk("rst_a_rdata", 16'(a_rdata), 16'h0);

        next_cycle();
        rst_n = 1'b1;

        // Test 1: 16-cycle clear sweep.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("clr_we_%0d", i), 16'(ram_we), 16'h1);
            chk($sformatf("clr_addr_%0d", i), 16'(ram_addr), 16'(i));
            chk($sformatf("clr_din_%0d", i), 16'(ram_din), 16'h00);
            chk($sformatf("clr_a_gnt_%0d", i), 16'(a_gnt), 16'h0);
            chk($sformatf("clr_b_gnt_%0d", i), 16'(b_gnt), 16'h0);
            chk($sformatf("clr_init_%0d", i), 16'(init_done), 16'h0);
            next_cycle();
        end

        // R0: A wins the first contested cycle.
        @(negedge clk);
        chk("r0_init_done", 16'(init_done), 16'h1);
        chk("r0_a_gnt", 16'(a_gnt), 16'h1);
        chk("r0_b_gnt", 16'(b_gnt), 16'h0);
        chk("r0_ram_we", 16'(ram_we), 16'h1);
        chk("r0_ram_addr", 16'(ram_addr), 16'h0);
        chk("r0_ram_din", 16'(ram_din), 16'hA5);
        chk("r0_a2_gnt", 16'(a2_gnt), 16'h1);
        next_cycle();
        a_req = 1'b0; a2_req = 1'b0;

        // R1: B's pending write.
        @(negedge clk);
        chk("r1_b_gnt", 16'(b_gnt), 16'h1);
        chk("r1_a_gnt", 16'(a_gnt), 16'h0);
        chk("r1_ram_addr", 16'(ram_addr), 16'h1);
        chk("r1_ram_din", 16'(ram_din), 16'h3C);
        chk("r1_a2_rvalid", 16'(a2_rvalid), 16'h1);
        chk("r1_a2_rdata_ff", 16'(a2_rdata), 16'hFF);
        next_cycle();
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h0;
        b_we = 1'b0; b_addr = 4'h1;

        // Test 3: alternating reads.
        @(negedge clk);
        chk("r2_a_gnt", 16'(a_gnt), 16'h1);
        chk("r2_b_gnt", 16'(b_gnt), 16'h0);
        chk("r2_ram_we", 16'(ram_we), 16'h0);
        chk("r2_a_rvalid", 16'(a_rvalid), 16'h0);
        chk("r2_a_rdata", 16'(a_rdata), 16'h00);
        next_cycle();
        @(negedge clk);
        chk("r3_b_gnt", 16'(b_gnt), 16'h1);
        chk("r3_ram_addr", 16'(ram_addr), 16'h1);
        chk("r3_a_rvalid", 16'(a_rvalid), 16'h1);
        chk("r3_a_rdata", 16'(a_rdata), 16'hA5);
        chk("r3_b_rvalid", 16'(b_rvalid), 16'h0);
        next_cycle();
        @(negedge clk);
        chk("r4_a_gnt", 16'(a_gnt), 16'h1);
        chk("r4_b_rvalid", 16'(b_rvalid), 16'h1);
        chk("r4_b_rdata", 16'(b_rdata), 16'h3C);
        chk("r4_a_rvalid", 16'(a_rvalid), 16'h0);
        next_cycle();
        @(negedge clk);
        chk("r5_b_gnt", 16'(b_gnt), 16'h1);
        chk("r5_a_rvalid", 16'(a_rvalid), 16'h1);
        chk("r5_a_rdata", 16'(a_rdata), 16'hA5);
        next_cycle();
        a_we = 1'b1; a_addr = 4'h2; a_wdata = 8'h7E;
        b_req = 1'b0;

        // Test 4: write then read-after-write from the other requester.
        @(negedge clk);
        chk("r6_a_gnt", 16'(a_gnt), 16'h1);
        chk("r6_ram_we", 16'(ram_we), 16'h1);
        chk("r6_ram_addr", 16'(ram_addr), 16'h2);
        chk("r6_ram_din", 16'(ram_din), 16'h7E);
        chk("r6_b_rvalid", 16'(b_rvalid), 16'h1);
        chk("r6_b_rdata", 16'(b_rdata), 16'h3C);
        next_cycle();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h2;
        @(negedge clk);
        chk("r7_b_gnt", 16'(b_gnt), 16'h1);
        chk("r7_a_gnt", 16'(a_gnt), 16'h0);
        chk("r7_b_rvalid", 16'(b_rvalid), 16'h0);
        next_cycle();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h9;

        // Test 5: unwritten locations read the clear value.
        @(negedge clk);
        chk("r8_b_rvalid", 16'(b_rvalid), 16'h1);
        chk("r8_b_rdata_raw", 16'(b_rdata), 16'h7E);
        chk("r8_a_gnt", 16'(a_gnt), 16'h1);
        chk("r8_ram_addr", 16'(ram_addr), 16'h9);
        next_cycle();
        a_addr = 4'hF;
        @(negedge clk);
        chk("r9_a_rvalid", 16'(a_rvalid), 16'h1);
        chk("r9_a_rdata_9", 16'(a_rdata), 16'h00);
        chk("r9_ram_addr", 16'(ram_addr), 16'hF);
        next_cycle();
        a_addr = 4'h5;
        @(negedge clk);
        chk("r10_a_rvalid", 16'(a_rvalid), 16'h1);
        chk("r10_a_rdata_f", 16'(a_rdata), 16'h00);
        chk("r10_a_gnt", 16'(a_gnt), 16'h1);

        // Test 6: reset while the addr-5 read is in flight.
        #1;
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        chk("mid_rst_a_rvalid", 16'(a_rvalid), 16'h0);
        chk("mid_rst_init_done", 16'(init_done), 16'h0);
        chk("mid_rst_a_gnt", 16'(a_gnt), 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_a_rvalid_late", 16'(a_rvalid), 16'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("resweep_we", 16'(ram_we), 16'h1);
        chk("resweep_addr0", 16'(ram_addr), 16'h0);
        chk("resweep_init", 16'(init_done), 16'h0);
        chk("resweep_a_rvalid", 16'(a_rvalid), 16'h0);
        next_cycle();
        @(negedge clk);
        chk("resweep_addr1", 16'(ram_addr), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
